// File: rtl/text_line_driver.sv
// Text line driver: fetches a string from text memory and feeds it, one glyph at a
// time, to a character renderer while advancing a pen cursor with wrap and clipping.
module text_line_driver #(
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 7,
  parameter int unsigned CHAR_W = 7,
  parameter int unsigned SIZE_W = 4,
  parameter int unsigned LEN_W  = 6,
  parameter int unsigned FONT_W = 5,
  parameter int unsigned FONT_H = 7
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_text_length,
  input  logic [X_W-1:0]    i_origin_x,
  input  logic [Y_W-1:0]    i_origin_y,
  input  logic [SIZE_W-1:0] i_size,
  input  logic [X_W-1:0]    i_bound_x,
  input  logic [Y_W-1:0]    i_bound_y,
  output logic [LEN_W-1:0]  o_mem_addr,
  input  logic [CHAR_W-1:0] i_mem_data,
  output logic [CHAR_W-1:0] o_char,
  output logic [X_W-1:0]    o_char_origin_x,
  output logic [Y_W-1:0]    o_char_origin_y,
  output logic [SIZE_W-1:0] o_char_size,
  output logic              o_char_enable,
  input  logic              i_char_finished,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_truncated
);

  localparam int unsigned XE = X_W + 1;
  localparam int unsigned YE = Y_W + 1;
  localparam int unsigned LE = LEN_W + 1;
  localparam logic [CHAR_W-1:0] CharNl = CHAR_W'(10);
  localparam logic [CHAR_W-1:0] CharSp = CHAR_W'(32);

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StCheck, StRender, StNext, StDone
  } state_t;

  state_t r_state, w_state_next;

  logic [LEN_W-1:0]  r_len, r_idx;
  logic [X_W-1:0]    r_org_x, r_bnd_x, r_pen_x;
  logic [Y_W-1:0]    r_org_y, r_bnd_y, r_pen_y;
  logic [SIZE_W-1:0] r_size;

  // One extra bit on every cursor sum so overflow past a bound is never aliased.
  logic [X_W:0] w_adv_x, w_pen_x_adv;
  logic [Y_W:0] w_adv_y, w_glyph_h, w_pen_y_adv, w_pen_y_bot;
  logic         w_is_nl, w_is_sp, w_wrap, w_clip, w_last;

  assign w_adv_x     = XE'(r_size) * XE'(FONT_W + 1);
  assign w_adv_y     = YE'(r_size) * YE'(FONT_H + 1);
  assign w_glyph_h   = YE'(r_size) * YE'(FONT_H);
  assign w_pen_x_adv = XE'(r_pen_x) + w_adv_x;
  assign w_pen_y_adv = YE'(r_pen_y) + w_adv_y;
  assign w_pen_y_bot = YE'(r_pen_y) + w_glyph_h;
  assign w_is_nl     = (i_mem_data == CharNl);
  assign w_is_sp     = (i_mem_data == CharSp);
  // A glyph already at the left margin never wraps, otherwise it would loop forever.
  assign w_wrap      = (w_pen_x_adv > XE'(r_bnd_x)) && (r_pen_x != r_org_x);
  assign w_clip      = (w_pen_y_bot > YE'(r_bnd_y));
  assign w_last      = ((LE'(r_idx) + LE'(1)) == LE'(r_len));

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (i_start) w_state_next = (i_text_length == '0) ? StDone : StFetch;
      StFetch:  w_state_next = StWait;
      StWait:   w_state_next = StCheck;
      StCheck: begin
        if (w_is_nl || w_is_sp) w_state_next = StNext;
        else if (w_wrap)        w_state_next = StCheck;
        else if (w_clip)        w_state_next = StDone;
        else                    w_state_next = StRender;
      end
      StRender: if (i_char_finished) w_state_next = StNext;
      StNext:   w_state_next = w_last ? StDone : StFetch;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_len <= '0; r_idx <= '0; r_size <= '0;
      r_org_x <= '0; r_bnd_x <= '0; r_pen_x <= '0;
      r_org_y <= '0; r_bnd_y <= '0; r_pen_y <= '0;
      o_mem_addr <= '0; o_char <= '0; o_char_origin_x <= '0; o_char_origin_y <= '0;
      o_char_size <= '0; o_char_enable <= 1'b0;
      o_busy <= 1'b0; o_done <= 1'b0; o_truncated <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_len <= i_text_length; r_size <= i_size;
            r_org_x <= i_origin_x; r_bnd_x <= i_bound_x; r_pen_x <= i_origin_x;
            r_org_y <= i_origin_y; r_bnd_y <= i_bound_y; r_pen_y <= i_origin_y;
            r_idx <= '0;
            o_truncated <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        StFetch: o_mem_addr <= r_idx;
        StCheck: begin
          if (w_is_nl || (!w_is_sp && w_wrap)) begin
            r_pen_x <= r_org_x;
            r_pen_y <= w_pen_y_adv[Y_W-1:0];
          end else if (w_is_sp) begin
            r_pen_x <= w_pen_x_adv[X_W-1:0];
          end else if (w_clip) begin
            o_truncated <= 1'b1;
          end else begin
            o_char <= i_mem_data;
            o_char_origin_x <= r_pen_x;
            o_char_origin_y <= r_pen_y;
            o_char_size <= r_size;
            o_char_enable <= 1'b1;
          end
        end
        StRender: begin
          if (i_char_finished) begin
            o_char_enable <= 1'b0;
            r_pen_x <= w_pen_x_adv[X_W-1:0];
          end
        end
        StNext: r_idx <= r_idx + LEN_W'(1);
        StDone: begin
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_text_line_driver.sv
// Self-checking bench for text_line_driver: directed table, reset/start corner cases
// and randomized strings checked against a behavioural layout model.
module tb_text_line_driver;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [5:0] text_length, mem_addr;
  logic [7:0] origin_x, bound_x, char_origin_x;
  logic [6:0] origin_y, bound_y, char_origin_y;
  logic [3:0] size, char_size;
  logic [6:0] mem_data, char_code;
  logic       char_enable, char_finished, busy, done, truncated;

  always #5 clk = ~clk;

  text_line_driver dut (
    .i_clock(clk), .i_reset(reset), .i_start(start), .i_text_length(text_length),
    .i_origin_x(origin_x), .i_origin_y(origin_y), .i_size(size),
    .i_bound_x(bound_x), .i_bound_y(bound_y), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
    .o_char(char_code), .o_char_origin_x(char_origin_x), .o_char_origin_y(char_origin_y),
    .o_char_size(char_size), .o_char_enable(char_enable), .i_char_finished(char_finished),
    .o_busy(busy), .o_done(done), .o_truncated(truncated)
  );

  // Text memory with one cycle of read latency.
  logic [6:0] mem [64];
  always @(posedge clk) mem_data <= mem[mem_addr];

  // Renderer: raises finished 'lat' cycles after enable, held while enabled.
  int lat = 4;
  int rcnt = 0;
  always @(posedge clk) begin
    if (!char_enable)    rcnt <= 0;
    else if (rcnt != lat) rcnt <= rcnt + 1;
  end
  assign char_finished = char_enable && (rcnt == lat);

  typedef struct { int c; int x; int y; int s; } rend_t;
  rend_t exp_q[$];
  rend_t got_q[$];
  int exp_trunc, exp_cyc;
  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, req);
  endtask

  // Layout rules applied directly to the string.
  task automatic model(input int len, input int ox, input int oy, input int sz,
                       input int bx, input int by);
    int px, py, ax, ay, gh;
    rend_t r;
    exp_q.delete();
    exp_trunc = 0;
    exp_cyc = 1;
    ax = sz * 6; ay = sz * 8; gh = sz * 7;
    px = ox; py = oy;
    for (int i = 0; i < len; i++) begin
      int c = int'(mem[i]);
      if (c == 10) begin
        px = ox; py = (py + ay) % 128; exp_cyc += 4;
      end else if (c == 32) begin
        px = (px + ax) % 256; exp_cyc += 4;
      end else begin
        exp_cyc += 3;
        if (px + ax > bx && px != ox) begin
          px = ox; py = (py + ay) % 128; exp_cyc += 1;
        end
        if (py + gh > by) begin
          exp_trunc = 1;
          break;
        end
        r.c = c; r.x = px; r.y = py; r.s = sz;
        exp_q.push_back(r);
        exp_cyc += lat + 2;
        px = (px + ax) % 256;
      end
    end
  endtask

  task automatic launch(input int len, input int ox, input int oy, input int sz,
                        input int bx, input int by);
    @(negedge clk);
    text_length = 6'(len); origin_x = 8'(ox); origin_y = 7'(oy); size = 4'(sz);
    bound_x = 8'(bx); bound_y = 7'(by);
    start = 1'b1;
  endtask

  task automatic run_string(input string tag, input int len, input int ox, input int oy,
                            input int sz, input int bx, input int by);
    bit prev_en = 0, busy_ok = 1, stable_ok = 1;
    int lat_got = -1;
    rend_t r;
    got_q.delete();
    launch(len, ox, oy, sz, bx, by);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (char_enable && !prev_en) begin
        r.c = int'(char_code); r.x = int'(char_origin_x); r.y = int'(char_origin_y);
        r.s = int'(char_size);
        got_q.push_back(r);
      end else if (char_enable && got_q.size() > 0) begin
        r = got_q[got_q.size()-1];
        if (r.c != int'(char_code) || r.x != int'(char_origin_x) ||
            r.y != int'(char_origin_y) || r.s != int'(char_size)) stable_ok = 0;
      end
      prev_en = char_enable;
      if (done) begin
        lat_got = k;
        break;
      end
      if (!busy) busy_ok = 0;
      // Latched inputs must not matter after start; a start pulse while busy is ignored.
      start = (k == 4);
      origin_x = 8'($urandom); origin_y = 7'($urandom); size = 4'($urandom);
      bound_x = 8'($urandom); bound_y = 7'($urandom); text_length = 6'($urandom);
    end
    start = 1'b0;
    chk({tag, " done_latency"}, lat_got, exp_cyc);
    chk({tag, " busy_held"}, int'(busy_ok), 1);
    chk({tag, " outputs_stable"}, int'(stable_ok), 1);
    chk({tag, " render_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, " char"}, got_q[i].c, exp_q[i].c);
      chk({tag, " x"}, got_q[i].x, exp_q[i].x);
      chk({tag, " y"}, got_q[i].y, exp_q[i].y);
      chk({tag, " size"}, got_q[i].s, exp_q[i].s);
    end
    chk({tag, " truncated"}, int'(truncated), exp_trunc);
    chk({tag, " busy_after"}, int'(busy), 0);
    @(negedge clk);
    chk({tag, " done_single"}, int'(done), 0);
    chk({tag, " idle_enable"}, int'(char_enable), 0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] txt;   // char i in byte i
    int          len, ox, oy, sz, bx, by;
    int          n;
    logic [31:0] ec, ex, ey;
    int          trunc, cyc;
  } vec_t;
  vec_t vecs[6];

  task automatic load_vec(input int v);
    exp_q.delete();
    for (int i = 0; i < 4; i++) mem[i] = 7'(vecs[v].txt[8*i +: 8]);
    for (int j = 0; j < vecs[v].n; j++) begin
      rend_t r;
      r.c = int'(vecs[v].ec[8*j +: 8]); r.x = int'(vecs[v].ex[8*j +: 8]);
      r.y = int'(vecs[v].ey[8*j +: 8]); r.s = vecs[v].sz;
      exp_q.push_back(r);
    end
    exp_trunc = vecs[v].trunc;
    exp_cyc = vecs[v].cyc;
  endtask

  initial begin
    // name, text, len, ox, oy, sz, bx, by, renders, chars, xs, ys, truncated, cycles (lat 4)
    vecs[0] = '{"ab", 32'h0000_4241, 2, 10, 20, 1, 160, 120, 2,
                32'h0000_4241, 32'h0000_100A, 32'h0000_1414, 0, 19};
    vecs[1] = '{"a_nl_b", 32'h0042_0A41, 3, 10, 20, 1, 160, 120, 2,
                32'h0000_4241, 32'h0000_0A0A, 32'h0000_1C14, 0, 23};
    vecs[2] = '{"abcd_wrap", 32'h4443_4241, 4, 100, 20, 1, 120, 120, 4,
                32'h4443_4241, 32'h6470_6A64, 32'h1C14_1414, 0, 38};
    vecs[3] = '{"a_sp_b", 32'h0042_2041, 3, 0, 0, 2, 160, 120, 2,
                32'h0000_4241, 32'h0000_1800, 32'h0000_0000, 0, 23};
    vecs[4] = '{"clip", 32'h0000_4241, 2, 10, 110, 2, 160, 120, 0,
                32'h0, 32'h0, 32'h0, 1, 4};
    vecs[5] = '{"empty", 32'h0000_4241, 0, 10, 20, 1, 160, 120, 0,
                32'h0, 32'h0, 32'h0, 0, 1};

    for (int i = 0; i < 64; i++) mem[i] = 7'h41;
    reset = 1'b1; start = 1'b0; text_length = '0; origin_x = '0; origin_y = '0;
    size = '0; bound_x = '0; bound_y = '0;
    repeat (3) @(negedge clk);
    chk("reset enable", int'(char_enable), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset truncated", int'(truncated), 0);
    chk("reset outputs", int'({mem_addr, char_code, char_origin_x, char_origin_y, char_size}), 0);
    reset = 1'b0;

    lat = 4;
    for (int v = 0; v < 6; v++) begin
      load_vec(v);
      run_string(vecs[v].name, vecs[v].len, vecs[v].ox, vecs[v].oy, vecs[v].sz,
                 vecs[v].bx, vecs[v].by);
    end

    // Reset while rendering, then a clean restart from index 0.
    load_vec(0);
    launch(2, 10, 20, 1, 160, 120);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !char_enable; k++) @(negedge clk);
    chk("rst_mid enable_seen", int'(char_enable), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid enable", int'(char_enable), 0);
    chk("rst_mid busy", int'(busy), 0);
    chk("rst_mid done", int'(done), 0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid no_done", int'(done), 0);
    end
    run_string("restart", 2, 10, 20, 1, 160, 120);

    for (int t = 0; t < 40; t++) begin
      int len, ox, oy, sz, bx, by;
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
        int r = $urandom_range(0, 9);
        mem[i] = (r == 0) ? 7'd10 : (r == 1) ? 7'd32 : 7'(65 + $urandom_range(0, 25));
      end
      ox = $urandom_range(0, 200);
      oy = $urandom_range(0, 100);
      sz = $urandom_range(1, 4);
      bx = ox + $urandom_range(0, 120);
      if (bx > 255) bx = 255;
      by = $urandom_range(0, 127);
      lat = $urandom_range(0, 3);
      model(len, ox, oy, sz, bx, by);
      run_string("random", len, ox, oy, sz, bx, by);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/text_line_driver.md
Name: text_line_driver

Overview:
- Initiator side of the character-renderer handshake.
- Walks a string held in text memory and drives one glyph renderer through char/origin/size/enable, one character at a time.
- Advances a pen cursor, handles space, newline and right-edge wrap, and stops at the bottom bound.
- Sits between the layout/attribute logic and the glyph renderer.

Parameters:
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- CHAR_W, 7, character code width
- SIZE_W, 4, scale factor width
- LEN_W, 6, string length / address width
- FONT_W, 5, glyph width in font pixels
- FONT_H, 7, glyph height in font pixels

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin a string; sampled only in IDLE
- text_length  in  LEN_W  number of characters; latched at start
- origin_x  in  X_W  left margin / first pen x; latched at start
- origin_y  in  Y_W  first pen y; latched at start
- size  in  SIZE_W  scale factor; latched at start
- bound_x  in  X_W  exclusive right edge; latched at start
- bound_y  in  Y_W  exclusive bottom edge; latched at start
- mem_addr  out  LEN_W  text memory read address
- mem_data  in  CHAR_W  read data, valid exactly 1 cycle after mem_addr
- char  out  CHAR_W  code sent to the renderer
- char_origin_x  out  X_W  glyph top-left x
- char_origin_y  out  Y_W  glyph top-left y
- char_size  out  SIZE_W  scale sent to the renderer
- char_enable  out  1  renderer enable
- char_finished  in  1  renderer completion; held high while enabled
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of string
- truncated  out  1  set when the string stopped at bound_y; cleared on next start

Behaviour:
- Reset values: all outputs 0, state IDLE. Reset mid-operation drops char_enable on the same edge; no done pulse.
- Derived quantities, computed with 1 extra bit of width so overflow never aliases:
  - adv_x = size*(FONT_W+1)
  - adv_y = size*(FONT_H+1)
  - glyph_h = size*FONT_H
- IDLE:
  - start=1 latches all inputs, sets pen=(origin_x, origin_y), idx=0, clears truncated, asserts busy.
  - If text_length=0, go DONE; otherwise go FETCH.
- FETCH: mem_addr<=idx; go WAIT.
- WAIT: one cycle for memory latency; go CHECK.
- CHECK, in priority order:
  - 0x0A (newline): pen_x<=origin_x, pen_y+=adv_y; go NEXT.
  - 0x20 (space): pen_x+=adv_x; go NEXT.
  - Otherwise, if pen_x+adv_x>bound_x and pen_x!=origin_x: wrap (pen_x<=origin_x, pen_y+=adv_y) and stay in CHECK one more cycle.
  - Otherwise, if pen_y+glyph_h>bound_y: truncated<=1; go DONE.
  - Otherwise load char/char_origin=pen/char_size, char_enable<=1; go RENDER.
  - A glyph at pen_x==origin_x is never wrapped, even if wider than the bound; this prevents a livelock.
- RENDER: hold all char_* outputs stable. On char_finished=1: char_enable<=0, pen_x+=adv_x; go NEXT.
- NEXT:
  - char_enable is guaranteed low here for at least 1 cycle, so the renderer re-arms.
  - idx+=1. If idx+1==text_length go DONE, else FETCH.
- DONE: done=1 for one cycle, busy<=0; go IDLE. truncated holds until the next start.
- start while busy is ignored. char_finished outside RENDER is ignored.
- Pen arithmetic wraps modulo 2^X_W / 2^Y_W only after the bound checks. Cursor overflow past bound_x is detected by the extended-width compare.
- Cycle counts:
  - printable character: 3 (FETCH, WAIT, CHECK) + renderer cycles + 1 (NEXT)
  - space / newline: 4
  - each wrap adds 1

Test Plan:
- "AB", origin (10,20), size 1, bounds (160,120), renderer model finishes 4 cycles after enable -> renders at (10,20) then (16,20); enable low ≥1 cycle between them; single done pulse; busy low after; truncated=0.
- "A\nB", same setup -> A at (10,20), B at (10,28); newline causes no enable.
- "ABCD", origin (100,20), bound_x 120, size 1 -> A@100, B@106, C@112, D wraps to (100,28).
- "A B", size 2, origin (0,0) -> A at (0,0), B at (24,0); the space issues no enable.
- origin_y 110, bound_y 120, size 2, "AB" -> glyph_h=14 overflows, no enable, truncated=1, done pulses; text_length=0 -> done 2 cycles after start.
- Reset asserted during RENDER of "AB" -> char_enable, busy, done all 0 next edge; a subsequent start renders from idx 0 cleanly; start pulsed while busy has no effect.
